// File: rtl/seq_match_pkg.sv
// Shared state encoding for the sequence-match counter FSM.
package seq_match_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    HIT     = 2'd2,
    ILLEGAL = 2'd3
  } state_e;
endpackage

// File: rtl/sat_updown_cnt.sv
// Next-value logic for a saturating up/down counter; clr loads 0 (or 1 with inc).
module sat_updown_cnt #(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             sat_o
);
  localparam logic [CNT_W-1:0] MAX = '1;

  always_comb begin
    cnt_d_o = cnt_i;
    sat_o   = 1'b0;
    if (clr_i) begin
      cnt_d_o = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i) begin
      // At full scale the increment is dropped and reported instead of wrapping.
      if (cnt_i == MAX) sat_o = 1'b1;
      else              cnt_d_o = cnt_i + CNT_W'(1);
    end else if (dec_i && cnt_i != '0) begin
      cnt_d_o = cnt_i - CNT_W'(1);
    end
  end
endmodule

// File: rtl/seq_match_fsm.sv
// Counts seq==num matches during a valid burst, then replays one hit per match
// under hit_ready backpressure. Define SEQ_MASK_EN to add a masked compare.
module seq_match_fsm
  import seq_match_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] num_i,
  input  logic [DATA_W-1:0] seq_i,
`ifdef SEQ_MASK_EN
  input  logic [DATA_W-1:0] mask_i,
`endif
  output logic              hit_o,
  input  logic              hit_ready_i,
  output logic [STATE_W-1:0] state_o,
  output logic [STATE_W-1:0] n_state_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [CNT_W-1:0]  n_cnt_o,
  output logic              overflow_o
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               overflow_q, hit_q, in_ready_q;
  logic               match, inc, dec, clr, sat;

`ifdef SEQ_MASK_EN
  assign match = (((seq_i ^ num_i) & mask_i) == '0);
`else
  assign match = (seq_i == num_i);
`endif

  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    dec     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        clr = 1'b1;
        inc = valid_i & match;
        if (valid_i) state_d = COUNT;
      end
      COUNT: begin
        if (valid_i) inc = match;
        else         state_d = (cnt_q != '0) ? HIT : IDLE;
      end
      HIT: begin
        // cnt is >0 on entry, so the last handshake lands exactly at cnt==1.
        if (hit_ready_i) begin
          dec = 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      default: begin
        clr     = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  sat_updown_cnt #(.CNT_W(CNT_W)) u_cnt (
    .cnt_i   (cnt_q),
    .inc_i   (inc),
    .dec_i   (dec),
    .clr_i   (clr),
    .cnt_d_o (cnt_d),
    .sat_o   (sat)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      hit_q      <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_q | sat;
      hit_q      <= (state_d == HIT);
      in_ready_q <= (state_d != HIT);
    end
  end

  assign state_o    = state_q;
  assign n_state_o  = state_d;
  assign cnt_o      = cnt_q;
  assign n_cnt_o    = cnt_d;
  assign overflow_o = overflow_q;
  assign hit_o      = hit_q;
  assign in_ready_o = in_ready_q;
endmodule

// File: tb/tb_seq_match_fsm.sv
// Directed + randomized bench for seq_match_fsm against a pending-hit model.
module tb_seq_match_fsm;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset, valid, hit_ready;
  logic [DATA_W-1:0] num, seq;
`ifdef SEQ_MASK_EN
  logic [DATA_W-1:0] mask = '1;
`endif
  logic              in_ready, hit, overflow;
  logic [1:0]        state, n_state;
  logic [CNT_W-1:0]  cnt, n_cnt;

  int tests = 0, fails = 0;
  // model: mode 0 idle, 1 collecting, 2 replaying; pend = hits owed
  int m_mode = 0, m_pend = 0, m_ovf = 0;
  int hs = 0, hit_cyc = 0, nmatch = 0;

  always #5 clock = ~clock;

  seq_match_fsm #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock_i(clock), .reset_i(reset), .valid_i(valid), .in_ready_o(in_ready),
    .num_i(num), .seq_i(seq),
`ifdef SEQ_MASK_EN
    .mask_i(mask),
`endif
    .hit_o(hit), .hit_ready_i(hit_ready), .state_o(state), .n_state_o(n_state),
    .cnt_o(cnt), .n_cnt_o(n_cnt), .overflow_o(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_match(input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] n);
`ifdef SEQ_MASK_EN
    return ((s ^ n) & mask) == 0;
`else
    return s == n;
`endif
  endfunction

  task automatic step(input logic v, input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] n,
                      input logic hr, input logic rst);
    int nm, np, no;
    bit mt;
    valid = v; seq = s; num = n; hit_ready = hr; reset = rst;
    #1;
    mt = is_match(s, n);
    nm = m_mode; np = m_pend; no = m_ovf;
    if (m_mode == 0) begin
      if (v) begin nm = 1; np = mt ? 1 : 0; end
    end else if (m_mode == 1) begin
      if (v) begin
        if (mt) begin
          if (np == MAXC) no = 1;
          else np++;
        end
      end else nm = (np > 0) ? 2 : 0;
    end else if (hr) begin
      np--;
      if (np == 0) nm = 0;
    end
    if (m_mode != 2 && v && mt) nmatch++;
    if (!rst) begin
      chk("n_state", 32'(n_state), 32'(nm));
      chk("n_cnt", 32'(n_cnt), 32'(np));
    end
    if (hit) hit_cyc++;
    if (hit && hr) hs++;
    if (rst) begin nm = 0; np = 0; no = 0; end
    m_mode = nm; m_pend = np; m_ovf = no;
    @(posedge clock); #1;
    chk("state", 32'(state), 32'(m_mode));
    chk("cnt", 32'(cnt), 32'(m_pend));
    chk("hit", 32'(hit), 32'(m_mode == 2));
    chk("in_ready", 32'(in_ready), 32'(m_mode != 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // kind: 0 never match, 1 always match, 2 random
  task automatic burst(input int len, input int kind);
    logic [DATA_W-1:0] n, s;
    for (int i = 0; i < len; i++) begin
      n = DATA_W'($urandom);
      case (kind)
        0:       s = ~n;
        1:       s = n;
        default: s = $urandom_range(0, 1) ? n : DATA_W'($urandom);
      endcase
      step(1'b1, s, n, 1'($urandom), 1'b0);
    end
  endtask

  // hrmode: 0 random, 1 always ready, 2 alternating 1,0,1,...
  task automatic drain(input int hrmode);
    int k = 0;
    logic hr;
    step(1'b0, DATA_W'($urandom), DATA_W'($urandom), 1'($urandom), 1'b0);
    while (m_mode == 2 && k < 200) begin
      hr = (hrmode == 1) ? 1'b1 : (hrmode == 2) ? (k % 2 == 0) : 1'($urandom);
      step(1'($urandom), DATA_W'($urandom), DATA_W'($urandom), hr, 1'b0);
      k++;
    end
    chk("drain_timeout", 32'(k < 200), 32'd1);
  endtask

  task automatic clr_counts();
    hs = 0; hit_cyc = 0; nmatch = 0;
  endtask

  initial begin
    valid = 0; seq = 0; num = 0; hit_ready = 0; reset = 1;
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    clr_counts(); burst(10, 0); drain(1);
    chk("nomatch_hits", 32'(hit_cyc), 32'd0);

    clr_counts(); burst(10, 1); drain(1);
    chk("ten_hit_cycles", 32'(hit_cyc), 32'd10);
    chk("ten_hs", 32'(hs), 32'd10);

    clr_counts(); burst(1, 1); drain(1);
    chk("one_hit", 32'(hs), 32'd1);
    clr_counts(); burst(1, 0); drain(1);
    chk("one_nohit", 32'(hit_cyc), 32'd0);

    clr_counts(); burst(3, 1); drain(2);
    chk("bp_hit_cycles", 32'(hit_cyc), 32'd5);
    chk("bp_hs", 32'(hs), 32'd3);

    clr_counts(); burst(20, 1); drain(1);
    chk("sat_hs", 32'(hs), 32'(MAXC));
    chk("sat_ovf", 32'(overflow), 32'd1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    burst(4, 1);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("mid_drain_cnt4", 32'(cnt), 32'd4);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);

`ifdef SEQ_MASK_EN
    mask = 4'b0011;
    clr_counts();
    step(1'b1, 4'd9, 4'd5, 1'b0, 1'b0);
    drain(1);
    chk("mask_hs", 32'(hs), 32'd1);
    mask = '1;
`endif

    step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int r = 0; r < 30; r++) begin
      clr_counts();
      burst($urandom_range(0, 20), 2);
      drain(0);
      chk("rand_hs", 32'(hs), 32'(nmatch > MAXC ? MAXC : nmatch));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
